// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite signal bundle between one master and the SRAM slave.
interface ahb_sram_slave_if;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [31:0] hwdata;
   logic        hready;
   logic        hreadyout;
   logic        hresp;
   logic [31:0] hrdata;

   modport slave (
      input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
      output hreadyout, hresp, hrdata
   );

   modport master (
      output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
      input  hreadyout, hresp, hrdata
   );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM target: byte/halfword/word access, programmable wait states,
// two-cycle ERROR response for out-of-range, oversized or misaligned transfers.
module ahb_sram_slave #(
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic            hclk,
   input  logic            hresetn,
   ahb_sram_slave_if.slave bus
);
   localparam int unsigned BYTES = DEPTH * 4;
   localparam int unsigned AW    = $clog2(BYTES);
   localparam int unsigned IW    = AW - 2;
   localparam logic [3:0]  WS    = 4'(WAIT_STATES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_DATA,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [3:0]    r_cnt;
   logic [3:0]    w_cnt_nxt;
   logic [AW-1:0] r_addr;
   logic          r_write;
   logic [1:0]    r_size;
   logic [31:0]   r_mem [DEPTH];

   logic          w_open;
   logic          w_accept;
   logic          w_legal;
   logic [3:0]    w_be;
   logic [IW-1:0] w_idx;
   logic          w_unused;

   // burst type and the SEQ/NONSEQ distinction carry no meaning here
   assign w_unused = ^{bus.hburst, bus.htrans[0]};

   assign w_open   = (r_state == S_IDLE) || (r_state == S_DATA) || (r_state == S_ERR2);
   assign w_accept = w_open && bus.hsel && bus.hready && bus.htrans[1];
   assign w_legal  = (bus.haddr < 32'(BYTES)) &&
                     ((bus.hsize == 3'd0) ||
                      ((bus.hsize == 3'd1) && !bus.haddr[0]) ||
                      ((bus.hsize == 3'd2) && (bus.haddr[1:0] == 2'b00)));
   assign w_idx    = r_addr[AW-1:2];

   // state and address-phase capture
   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_write <= 1'b0;
         r_size  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_addr  <= bus.haddr[AW-1:0];
            r_write <= bus.hwrite;
            r_size  <= bus.hsize[1:0];
         end
      end
   end

   // next state and bus response
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      bus.hreadyout = 1'b1;
      bus.hresp     = 1'b0;
      case (r_state)
         S_WAIT: begin
            bus.hreadyout = 1'b0;
            w_cnt_nxt     = r_cnt - 4'd1;
            if (r_cnt <= 4'd1) begin
               w_state_nxt = S_DATA;
            end
         end
         S_ERR1: begin
            bus.hreadyout = 1'b0;
            bus.hresp     = 1'b1;
            w_state_nxt   = S_ERR2;
         end
         S_ERR2: begin
            bus.hresp = 1'b1;
         end
         default: ;
      endcase
      if (w_open) begin
         if (!w_accept) begin
            w_state_nxt = S_IDLE;
         end else if (!w_legal) begin
            w_state_nxt = S_ERR1;
         end else if (WS == 4'd0) begin
            w_state_nxt = S_DATA;
         end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = WS;
         end
      end
   end

   // little-endian lane select; halfword lanes chosen by address bit 1
   always_comb begin
      w_be = 4'b0000;
      case (r_size)
         2'd0:    w_be[r_addr[1:0]] = 1'b1;
         2'd1:    w_be = r_addr[1] ? 4'b1100 : 4'b0011;
         default: w_be = 4'b1111;
      endcase
   end

   always_ff @(posedge hclk) begin
      if (hresetn && (r_state == S_DATA) && r_write) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
               r_mem[w_idx][8*b +: 8] <= bus.hwdata[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      bus.hrdata = '0;
      if ((r_state == S_DATA) && !r_write) begin
         bus.hrdata = r_mem[w_idx];
      end
   end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Randomised plus directed scoreboard bench for ahb_sram_slave at three wait-state settings.
module tb_ahb_sram_slave;
   localparam int unsigned DEPTH = 1024;
   localparam int unsigned BYTES = DEPTH * 4;
   localparam int unsigned NDUT  = 3;
   localparam int unsigned WS0   = 0;
   localparam int unsigned WS1   = 2;
   localparam int unsigned WS2   = 3;

   logic hclk = 1'b0;
   logic hresetn;
   always #5 hclk = ~hclk;

   logic        m_hsel;
   logic [31:0] m_haddr;
   logic [1:0]  m_htrans;
   logic        m_hwrite;
   logic [2:0]  m_hsize;
   logic [2:0]  m_hburst;
   logic [31:0] m_hwdata;
   int          dsel;

   ahb_sram_slave_if if0 ();
   ahb_sram_slave_if if1 ();
   ahb_sram_slave_if if2 ();

   ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(WS0)) u_dut0 (.hclk(hclk), .hresetn(hresetn), .bus(if0));
   ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(WS1)) u_dut1 (.hclk(hclk), .hresetn(hresetn), .bus(if1));
   ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(WS2)) u_dut2 (.hclk(hclk), .hresetn(hresetn), .bus(if2));

   assign if0.hsel   = m_hsel && (dsel == 0);
   assign if0.haddr  = m_haddr;
   assign if0.htrans = m_htrans;
   assign if0.hwrite = m_hwrite;
   assign if0.hsize  = m_hsize;
   assign if0.hburst = m_hburst;
   assign if0.hwdata = m_hwdata;
   assign if0.hready = if0.hreadyout;
   assign if1.hsel   = m_hsel && (dsel == 1);
   assign if1.haddr  = m_haddr;
   assign if1.htrans = m_htrans;
   assign if1.hwrite = m_hwrite;
   assign if1.hsize  = m_hsize;
   assign if1.hburst = m_hburst;
   assign if1.hwdata = m_hwdata;
   assign if1.hready = if1.hreadyout;
   assign if2.hsel   = m_hsel && (dsel == 2);
   assign if2.haddr  = m_haddr;
   assign if2.htrans = m_htrans;
   assign if2.hwrite = m_hwrite;
   assign if2.hsize  = m_hsize;
   assign if2.hburst = m_hburst;
   assign if2.hwdata = m_hwdata;
   assign if2.hready = if2.hreadyout;

   logic        s_rdy;
   logic        s_resp;
   logic [31:0] s_rdata;
   always_comb begin
      case (dsel)
         1:       {s_rdy, s_resp, s_rdata} = {if1.hreadyout, if1.hresp, if1.hrdata};
         2:       {s_rdy, s_resp, s_rdata} = {if2.hreadyout, if2.hresp, if2.hrdata};
         default: {s_rdy, s_resp, s_rdata} = {if0.hreadyout, if0.hresp, if0.hrdata};
      endcase
   end

   int errors = 0;
   int checks = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic void finish_now(string why);
      errors++;
      checks++;
      $display("FAIL %s: bound expired (t=%0t)", why, $time);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   endfunction

   // Reference model: byte-addressed memory with a known-byte map per DUT
   logic [7:0] mem8   [NDUT][BYTES];
   bit         known8 [NDUT][BYTES];

   typedef struct {
      string       tag;
      logic        resp;
      logic        chk_rd;
      logic [31:0] rdata;
      int          waits;
   } exp_t;

   exp_t exp_q[$];

   function automatic int ws_of(int d);
      return (d == 0) ? int'(WS0) : (d == 1) ? int'(WS1) : int'(WS2);
   endfunction

   function automatic exp_t model_xfer(int d, logic sel, logic [1:0] trans, logic wr,
                                       logic [2:0] size, logic [31:0] addr, logic [31:0] wdata);
      exp_t e;
      int unsigned n;
      int unsigned base;
      e.tag = "";
      e.resp = 1'b0;
      e.chk_rd = 1'b1;
      e.rdata = '0;
      e.waits = 0;
      if (!(sel && (trans == 2'd2 || trans == 2'd3))) return e;
      if (size > 3'd2) begin
         e.resp = 1'b1;
         e.waits = 1;
         return e;
      end
      n = 1 << size;
      if (addr >= BYTES || (addr % n) != 0) begin
         e.resp = 1'b1;
         e.waits = 1;
         return e;
      end
      e.waits = ws_of(d);
      if (wr) begin
         for (int unsigned i = 0; i < n; i++) begin
            mem8[d][addr + i]   = wdata[8 * ((addr + i) % 4) +: 8];
            known8[d][addr + i] = 1'b1;
         end
      end else begin
         base = addr - (addr % 4);
         for (int unsigned i = 0; i < 4; i++) begin
            if (!known8[d][base + i]) e.chk_rd = 1'b0;
            e.rdata[8 * i +: 8] = mem8[d][base + i];
         end
      end
      return e;
   endfunction

   // Issue one address phase; returns just after the edge that accepted it
   task automatic xfer(input string tag, input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] burst, input logic k_en, input logic [31:0] k_val);
      exp_t e;
      logic rdy;
      int   n;
      m_hsel   = sel;
      m_htrans = trans;
      m_hwrite = wr;
      m_hsize  = size;
      m_haddr  = addr;
      m_hburst = burst;
      n = 0;
      forever begin
         @(negedge hclk);
         rdy = s_rdy;
         @(posedge hclk);
         if (rdy) break;
         n++;
         if (n > 40) finish_now({tag, "_accept"});
      end
      e = model_xfer(dsel, sel, trans, wr, size, addr, wdata);
      e.tag = tag;
      if (k_en) begin
         e.rdata  = k_val;
         e.chk_rd = 1'b1;
      end
      exp_q.push_back(e);
      #1;
      m_hwdata = wdata;
   endtask

   task automatic wr_t(input string tag, input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata);
      xfer(tag, 1'b1, 2'd2, 1'b1, size, addr, wdata, 3'd0, 1'b0, '0);
   endtask

   task automatic rd_k(input string tag, input logic [31:0] addr, input logic [31:0] k_val);
      xfer(tag, 1'b1, 2'd2, 1'b0, 3'd2, addr, '0, 3'd0, 1'b1, k_val);
   endtask

   task automatic rd_t(input string tag, input logic [2:0] size, input logic [31:0] addr);
      xfer(tag, 1'b1, 2'd2, 1'b0, size, addr, '0, 3'd0, 1'b0, '0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      xfer("idle", 1'b0, 2'd0, 1'b0, 3'd2, '0, '0, 3'd0, 1'b0, '0);
      while (exp_q.size() != 0) begin
         @(posedge hclk);
         n++;
         if (n > 60) finish_now("drain");
      end
      #1;
   endtask

   // Monitor: compares each data phase against the head of the queue
   int wcnt = 0;
   always @(negedge hclk) begin
      exp_t e;
      if (!hresetn) begin
         wcnt = 0;
      end else if (exp_q.size() > 0) begin
         e = exp_q[0];
         if (!s_rdy) begin
            wcnt++;
            check({e.tag, "_wait_resp"}, 32'(s_resp), 32'(e.resp));
            check({e.tag, "_wait_rdata"}, s_rdata, 32'h0);
            if (wcnt > 40) begin
               void'(exp_q.pop_front());
               wcnt = 0;
               errors++;
               checks++;
               $display("FAIL %s_complete: no completion after 40 cycles", e.tag);
            end
         end else begin
            void'(exp_q.pop_front());
            check({e.tag, "_resp"}, 32'(s_resp), 32'(e.resp));
            check({e.tag, "_waits"}, 32'(wcnt), 32'(e.waits));
            if (e.chk_rd) check({e.tag, "_rdata"}, s_rdata, e.rdata);
            wcnt = 0;
         end
      end
   end

   initial begin
      #400000;
      finish_now("global_timeout");
   end

   initial begin
      logic        sel;
      logic        wr;
      logic [1:0]  trans;
      logic [2:0]  size;
      logic [31:0] addr;
      int unsigned r;

      m_hsel = 1'b0; m_haddr = '0; m_htrans = 2'd0; m_hwrite = 1'b0;
      m_hsize = 3'd0; m_hburst = 3'd0; m_hwdata = '0; dsel = 0;
      hresetn = 1'b0;
      repeat (3) @(posedge hclk);
      #1;
      check("rst0_rdy", 32'(if0.hreadyout), 32'h1);
      check("rst0_resp", 32'(if0.hresp), 32'h0);
      check("rst0_rdata", if0.hrdata, 32'h0);
      check("rst1_rdy", 32'(if1.hreadyout), 32'h1);
      check("rst1_resp", 32'(if1.hresp), 32'h0);
      check("rst2_rdy", 32'(if2.hreadyout), 32'h1);
      check("rst2_rdata", if2.hrdata, 32'h0);
      hresetn = 1'b1;

      // Zero wait states: write then back-to-back read, sub-word lanes
      dsel = 0;
      wr_t("t1_wr", 3'd2, 32'h10, 32'hDEAD_BEEF);
      rd_k("t1_rd", 32'h10, 32'hDEAD_BEEF);
      wr_t("t2_w", 3'd2, 32'h20, 32'h1122_3344);
      wr_t("t2_b", 3'd0, 32'h21, 32'h0000_AA00);
      wr_t("t2_h", 3'd1, 32'h22, 32'h5566_0000);
      rd_k("t2_rd", 32'h20, 32'h5566_AA44);
      // Illegal transfers, including misaligned writes that must not land
      rd_t("t4_mis", 3'd2, 32'h1002);
      rd_t("t4_oob", 3'd2, BYTES);
      rd_t("t4_sz3", 3'd3, 32'h30);
      wr_t("t4_wmisw", 3'd2, 32'h12, 32'hFFFF_FFFF);
      wr_t("t4_wmish", 3'd1, 32'h11, 32'hFFFF_FFFF);
      rd_k("t4_back", 32'h10, 32'hDEAD_BEEF);
      drain();

      // Three wait states: single read and INCR4 burst
      dsel = 2;
      for (int i = 0; i < 4; i++) wr_t("t3_fill", 3'd2, 32'h40 + 32'(4 * i), 32'hA000_0000 + 32'(i));
      rd_k("t3_single", 32'h44, 32'hA000_0001);
      xfer("t3_b0", 1'b1, 2'd2, 1'b0, 3'd2, 32'h40, '0, 3'd3, 1'b1, 32'hA000_0000);
      xfer("t3_b1", 1'b1, 2'd3, 1'b0, 3'd2, 32'h44, '0, 3'd3, 1'b1, 32'hA000_0001);
      xfer("t3_b2", 1'b1, 2'd3, 1'b0, 3'd2, 32'h48, '0, 3'd3, 1'b1, 32'hA000_0002);
      xfer("t3_b3", 1'b1, 2'd3, 1'b0, 3'd2, 32'h4C, '0, 3'd3, 1'b1, 32'hA000_0003);
      rd_t("t4_ws_err", 3'd1, 32'h41);
      // BUSY, IDLE and deselected transfers mid-burst leave memory alone
      xfer("t5_ns", 1'b1, 2'd2, 1'b0, 3'd2, 32'h40, '0, 3'd1, 1'b1, 32'hA000_0000);
      xfer("t5_busy", 1'b1, 2'd1, 1'b1, 3'd2, 32'h44, 32'h5555_5555, 3'd1, 1'b0, '0);
      xfer("t5_seq", 1'b1, 2'd3, 1'b0, 3'd2, 32'h44, '0, 3'd1, 1'b1, 32'hA000_0001);
      xfer("t5_idle", 1'b1, 2'd0, 1'b1, 3'd2, 32'h48, 32'h6666_6666, 3'd0, 1'b0, '0);
      xfer("t5_nosel", 1'b0, 2'd2, 1'b1, 3'd2, 32'h48, 32'hFFFF_FFFF, 3'd0, 1'b0, '0);
      rd_k("t5_back", 32'h48, 32'hA000_0002);
      drain();

      // Reset during the wait phase of a write drops it
      dsel = 1;
      wr_t("t6_pre", 3'd2, 32'h80, 32'h1234_5678);
      drain();
      m_hsel = 1'b1; m_htrans = 2'd2; m_hwrite = 1'b1; m_hsize = 3'd2; m_haddr = 32'h80;
      @(posedge hclk);
      #1;
      m_hwdata = 32'hCAFE_F00D;
      m_hsel = 1'b0; m_htrans = 2'd0;
      @(posedge hclk);
      #1;
      check("t6_in_wait", 32'(s_rdy), 32'h0);
      hresetn = 1'b0;
      @(posedge hclk);
      #1;
      check("t6_rst_rdy", 32'(s_rdy), 32'h1);
      check("t6_rst_resp", 32'(s_resp), 32'h0);
      check("t6_rst_rdata", s_rdata, 32'h0);
      hresetn = 1'b1;
      rd_k("t6_back", 32'h80, 32'h1234_5678);
      drain();

      // Randomised traffic on every wait-state setting
      for (int d = 0; d < int'(NDUT); d++) begin
         dsel = d;
         for (int i = 0; i < 120; i++) begin
            r     = $urandom_range(0, 15);
            sel   = (r != 0);
            trans = (r == 1) ? 2'd0 : (r == 2) ? 2'd1 : 2'(2 + $urandom_range(0, 1));
            size  = ($urandom_range(0, 19) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            addr  = 32'h100 + 32'($urandom_range(0, 127));
            if (size <= 3'd2 && $urandom_range(0, 3) != 0) addr = addr & ~(32'((1 << size) - 1));
            if ($urandom_range(0, 19) == 0) addr = BYTES + 32'($urandom_range(0, 255) * 4);
            wr = 1'($urandom_range(0, 1));
            xfer("rand", sel, trans, wr, size, addr, $urandom, 3'($urandom_range(0, 7)), 1'b0, '0);
         end
         drain();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
